// File: rtl/jt1943_rom_dwnld.sv
// Steers the MiST ioctl download stream into SDRAM programming writes and colour/priority PROM strobes.
// Also runs the end-of-download handshake and tracks overrun and checksum.
module jt1943_rom_dwnld #(
  parameter logic [21:0] PROM_START = 22'h3_C000,
  parameter int          PROM_COUNT = 12,
  parameter int          PROM_AW    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  downloading,
  input  logic [21:0]           ioctl_addr,
  input  logic [7:0]            ioctl_data,
  input  logic                  ioctl_wr,
  input  logic                  prog_ack,
  output logic [21:0]           prog_addr,
  output logic [7:0]            prog_data,
  output logic [1:0]            prog_mask,
  output logic                  prog_we,
  output logic [PROM_COUNT-1:0] prom_we,
  output logic [PROM_AW-1:0]    prom_addr,
  output logic [3:0]            prom_data,
  output logic                  dwnld_done,
  output logic                  overrun,
  output logic [7:0]            checksum
);

  localparam logic [21:0] PROM_END = PROM_START + (22'(PROM_COUNT) << PROM_AW);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  state_t                state_q, state_d;
  logic                  dl_q, dl_d;
  logic [21:0]           prog_addr_q, prog_addr_d;
  logic [7:0]            prog_data_q, prog_data_d;
  logic [1:0]            prog_mask_q, prog_mask_d;
  logic                  prog_we_q, prog_we_d;
  logic [PROM_COUNT-1:0] prom_we_q, prom_we_d;
  logic [PROM_AW-1:0]    prom_addr_q, prom_addr_d;
  logic [3:0]            prom_data_q, prom_data_d;
  logic                  dwnld_done_q, dwnld_done_d;
  logic                  overrun_q, overrun_d;
  logic [7:0]            checksum_q, checksum_d;

  logic        dl_rise, dl_fall, ack_done, is_sdram, is_prom;
  logic [21:0] prom_off, prom_idx;

  assign dl_rise  = downloading & ~dl_q;
  assign dl_fall  = ~downloading & dl_q;
  assign ack_done = prog_we_q & prog_ack;
  assign is_sdram = ioctl_addr < PROM_START;
  assign is_prom  = ~is_sdram & (ioctl_addr < PROM_END);
  assign prom_off = ioctl_addr - PROM_START;
  assign prom_idx = prom_off >> PROM_AW;

  always_comb begin
    state_d      = state_q;
    dl_d         = downloading;
    prog_addr_d  = prog_addr_q;
    prog_data_d  = prog_data_q;
    prog_mask_d  = prog_mask_q;
    prog_we_d    = prog_we_q;
    prom_we_d    = '0;
    prom_addr_d  = prom_addr_q;
    prom_data_d  = prom_data_q;
    dwnld_done_d = 1'b0;
    overrun_d    = overrun_q;
    checksum_d   = checksum_q;

    if (ack_done) prog_we_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (dl_rise) begin
          checksum_d = 8'h00;
          overrun_d  = 1'b0;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        if (ioctl_wr) begin
          if (is_sdram) begin
            // A pending, un-acked SDRAM write cannot be replaced, so the new byte is lost
            if (prog_we_q && !prog_ack) begin
              overrun_d = 1'b1;
            end else begin
              prog_addr_d = {1'b0, ioctl_addr[21:1]};
              prog_data_d = ioctl_data;
              prog_mask_d = ioctl_addr[0] ? 2'b01 : 2'b10;
              prog_we_d   = 1'b1;
              checksum_d  = checksum_q + ioctl_data;
            end
          end else if (is_prom) begin
            for (int i = 0; i < PROM_COUNT; i++) prom_we_d[i] = (prom_idx == 22'(i));
            prom_addr_d = ioctl_addr[PROM_AW-1:0];
            prom_data_d = ioctl_data[3:0];
            checksum_d  = checksum_q + ioctl_data;
          end
        end
        // Decide on the post-acceptance write state so a last-cycle byte still drains
        if (dl_fall) state_d = prog_we_d ? DRAIN : DONE;
      end
      DRAIN: begin
        if (ack_done) state_d = DONE;
      end
      DONE: begin
        dwnld_done_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      dl_q         <= 1'b0;
      prog_addr_q  <= '0;
      prog_data_q  <= '0;
      prog_mask_q  <= '0;
      prog_we_q    <= 1'b0;
      prom_we_q    <= '0;
      prom_addr_q  <= '0;
      prom_data_q  <= '0;
      dwnld_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      checksum_q   <= '0;
    end else begin
      state_q      <= state_d;
      dl_q         <= dl_d;
      prog_addr_q  <= prog_addr_d;
      prog_data_q  <= prog_data_d;
      prog_mask_q  <= prog_mask_d;
      prog_we_q    <= prog_we_d;
      prom_we_q    <= prom_we_d;
      prom_addr_q  <= prom_addr_d;
      prom_data_q  <= prom_data_d;
      dwnld_done_q <= dwnld_done_d;
      overrun_q    <= overrun_d;
      checksum_q   <= checksum_d;
    end
  end

  assign prog_addr  = prog_addr_q;
  assign prog_data  = prog_data_q;
  assign prog_mask  = prog_mask_q;
  assign prog_we    = prog_we_q;
  assign prom_we    = prom_we_q;
  assign prom_addr  = prom_addr_q;
  assign prom_data  = prom_data_q;
  assign dwnld_done = dwnld_done_q;
  assign overrun    = overrun_q;
  assign checksum   = checksum_q;

endmodule

// File: doc/jt1943_rom_dwnld.md
Name: jt1943_rom_dwnld

Overview:
- Converts the byte stream from the MiST I/O controller (ioctl_addr/ioctl_data/ioctl_wr) into SDRAM programming writes (prog_addr/prog_data/prog_mask/prog_we) and on-chip PROM write strobes.
- Sits directly upstream of the SDRAM programming port of the frame and of the game's colour/priority PROMs during ROM download.
- Also sequences the end-of-download handshake and reports overrun and checksum status.

Parameters:
- PROM_START, 22'h3_C000, byte address of the first PROM image; bytes below it go to SDRAM.
- PROM_COUNT, 12, number of 256-byte PROM images that follow PROM_START.
- PROM_AW, 8, PROM address width; each PROM occupies 2^PROM_AW bytes.

Ports:
- clk  in  1  system clock (48 MHz).
- rst_n  in  1  asynchronous active-low reset.
- downloading  in  1  high while the ROM file is being transferred.
- ioctl_addr  in  22  byte address of the incoming byte.
- ioctl_data  in  8  incoming byte.
- ioctl_wr  in  1  one-cycle strobe; the byte is valid in this cycle.
- prog_ack  in  1  SDRAM controller accepted the current write.
- prog_addr  out  22  SDRAM word address (ioctl_addr>>1).
- prog_data  out  8  byte to write, replicated to both lanes by the frame.
- prog_mask  out  2  active-low byte enable: 2'b10 = low byte, 2'b01 = high byte.
- prog_we  out  1  write request; held high until prog_ack.
- prom_we  out  PROM_COUNT  one-hot, one-cycle PROM write strobe.
- prom_addr  out  PROM_AW  PROM byte address.
- prom_data  out  4  PROM nibble (ioctl_data[3:0]).
- dwnld_done  out  1  one-cycle pulse once the download has ended and the final SDRAM write has been acked.
- overrun  out  1  sticky flag: a byte was dropped.
- checksum  out  8  modulo-256 sum of all accepted bytes.

Behaviour:
- Reset: all outputs 0, state IDLE. Reset is asynchronous, so it clears a write in progress; no ack is awaited.
- States:
  - IDLE: waits for the downloading rising edge. On the edge, clears checksum and overrun and goes to LOAD.
  - LOAD: accepts bytes. On the downloading falling edge, goes to DRAIN if prog_we=1, otherwise to DONE.
  - DRAIN: waits for prog_ack, then goes to DONE.
  - DONE: pulses dwnld_done for 1 cycle, then returns to IDLE.
- Byte acceptance happens only in LOAD. ioctl_wr outside LOAD is ignored.
- Accepted bytes add into checksum, wrapping modulo 256.
- SDRAM path (ioctl_addr < PROM_START):
  - The next cycle registers prog_addr={1'b0,ioctl_addr[21:1]}, prog_data=ioctl_data, prog_mask = ioctl_addr[0] ? 2'b01 : 2'b10, and prog_we=1. Latency is 1 cycle.
  - prog_we clears the cycle after prog_ack is sampled high. prog_addr, prog_data and prog_mask stay stable while prog_we=1.
  - A new SDRAM byte arriving while prog_we=1 and prog_ack=0 is dropped: overrun is set and checksum is not updated.
  - If prog_ack=1 in the same cycle as a new ioctl_wr, the new byte is accepted and prog_we stays high with the new values.
- PROM path (PROM_START <= addr < PROM_START + PROM_COUNT<<PROM_AW):
  - idx = (addr-PROM_START)>>PROM_AW.
  - The next cycle sets prom_we[idx]=1 for exactly 1 cycle, with prom_addr=addr[PROM_AW-1:0] and prom_data=ioctl_data[3:0].
  - A PROM write is never blocked by a pending SDRAM write.
- Addresses at or beyond the PROM area: ignored and not summed.
- prog_ack while prog_we=0: ignored.
- downloading dropping in the same cycle as ioctl_wr: the byte is accepted first, then the block goes to DRAIN.
- overrun and checksum hold their value after DONE until the next download starts.

Test Plan:
- Write 0x5A at addr 0x000001, then 0xA5 at 0x000000, with prog_ack 2 cycles after prog_we. Required:
  - First write: prog_addr=0, mask=2'b01, data=0x5A.
  - Second write: mask=2'b10, data=0xA5.
  - checksum=0xFF; overrun=0.
- Write 0x3C at addr 0x3C105 (PROM_START + 0x105). Required: prom_we=12'h002 for 1 cycle, prom_addr=0x05, prom_data=4'hC; prog_we stays 0.
- Two SDRAM bytes 1 cycle apart with prog_ack held low. Required: overrun=1, the first byte's values are held, and checksum counts only the first byte.
- Drop downloading while prog_we=1 and ack is delayed 5 cycles. Required: state is DRAIN, and dwnld_done pulses exactly once, 1 cycle after prog_we falls.
- Write to addr 0x3CC00 (beyond 12 PROMs) and pulse ioctl_wr while downloading=0. Required: no prom_we, no prog_we, and checksum unchanged.
- Assert rst_n=0 mid-write with prog_we=1. Required: all outputs 0 immediately; after release, state is IDLE until the next downloading rise.
